// File: rtl/j204c_tx_sample_gen.sv
// ---------------------------------------------------------------------------
// j204c_tx_sample_gen
//   Test-sample source feeding the JESD204C TX IP's tx_avst sink. Produces
//   ramp, constant, checkerboard and (optionally) PRBS7 beats, packed as
//   DATA_W/SAMPLE_W samples per beat with sample 0 in the low bits. Beats
//   are offered with a valid/ready handshake once the TX link is up; accepted
//   beats and stall cycles are counted.
//
//   Optional feature macro: J204C_TXGEN_PRBS_EN
//     defined   -> gen_mode 3 selects PRBS7 (x^7 + x^6 + 1)
//     undefined -> no LFSR is built; gen_mode 3 behaves as ramp
//
// Ports
//   jesd_link_clk   in   link clock, single clock domain
//   jesd_link_reset in   synchronous active-high reset
//   gen_enable      in   level, 1 = run generator
//   gen_mode        in   0 ramp, 1 constant, 2 checkerboard, 3 PRBS/ramp
//   gen_const       in   sample value for constant mode
//   link_up         in   TX link in user-data phase
//   tx_avst_data    out  beat data
//   tx_avst_valid   out  beat valid
//   tx_avst_ready   in   sink ready
//   beat_cnt        out  accepted beats since last start (saturating)
//   stall_cnt       out  RUN cycles with valid & !ready (saturating)
//   gen_busy        out  1 when the FSM is not idle
// ---------------------------------------------------------------------------
module j204c_tx_sample_gen #(
  parameter int DATA_W   = 256,
  parameter int SAMPLE_W = 16,
  parameter int CNT_W    = 32
) (
  input  logic                jesd_link_clk,
  input  logic                jesd_link_reset,
  input  logic                gen_enable,
  input  logic [1:0]          gen_mode,
  input  logic [SAMPLE_W-1:0] gen_const,
  input  logic                link_up,
  output logic [DATA_W-1:0]   tx_avst_data,
  output logic                tx_avst_valid,
  input  logic                tx_avst_ready,
  output logic [CNT_W-1:0]    beat_cnt,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic                gen_busy
);

  localparam int NS = DATA_W / SAMPLE_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARM   = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [SAMPLE_W-1:0] CHK_EVEN = {(SAMPLE_W/2){2'b01}};
  localparam logic [SAMPLE_W-1:0] CHK_ODD  = {(SAMPLE_W/2){2'b10}};

  logic [1:0]          state_q,     state_d;
  logic                valid_q,     valid_d;
  logic [DATA_W-1:0]   data_q,      data_d;
  logic [CNT_W-1:0]    beat_cnt_q,  beat_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;
  logic [SAMPLE_W-1:0] base_q,      base_d;     // ramp base of the next beat to generate
  logic                odd_q,       odd_d;      // checkerboard parity of the next beat
  logic                busy_q,      busy_d;

  logic                xfer;
  logic                stall;
  logic                start_run;
  logic                exiting;
  logic                gen_beat;
  logic                use_odd;
  logic [SAMPLE_W-1:0] chk_sample;
  logic [DATA_W-1:0]   ramp_beat;
  logic [DATA_W-1:0]   gen_data;

`ifdef J204C_TXGEN_PRBS_EN
  logic [6:0]          lfsr_q, lfsr_d;          // LFSR state at the start of the next beat
  logic [6:0]          lfsr_src;
  logic [6:0]          lfsr_nxt;
  logic [DATA_W+6:0]   prbs_res;

  // PRBS7 (x^7 + x^6 + 1): emits DATA_W bits, MSB of each sample first.
  // Returns {state after the beat, beat data}.
  function automatic logic [DATA_W+6:0] prbs7_beat(input logic [6:0] seed);
    logic [6:0]        st;
    logic              fb;
    logic [DATA_W-1:0] d;
    st = seed;
    d  = '0;
    for (int s = 0; s < NS; s++) begin
      for (int b = SAMPLE_W - 1; b >= 0; b--) begin
        fb = st[6] ^ st[5];
        st = {st[5:0], fb};
        d[s*SAMPLE_W + b] = fb;
      end
    end
    return {st, d};
  endfunction
`endif

  // Handshake qualifiers and beat-generation strobe.
  always_comb begin
    xfer      = valid_q & tx_avst_ready;
    stall     = (state_q == ST_RUN) & valid_q & ~tx_avst_ready;
    start_run = (state_q == ST_ARM) & gen_enable & link_up;
    exiting   = ~gen_enable | ~link_up;
    // A new beat is produced on entering RUN and after every transfer that
    // does not end the run.
    gen_beat  = start_run | ((state_q == ST_RUN) & xfer & ~exiting);
  end

  // Pattern generator: builds the beat that gen_beat would load.
  always_comb begin
    ramp_beat = '0;
    for (int i = 0; i < NS; i++) begin
      ramp_beat[i*SAMPLE_W +: SAMPLE_W] = base_q + SAMPLE_W'(i);
    end
    // A run always starts on an even checkerboard beat.
    if (start_run) begin
      use_odd = 1'b0;
    end else begin
      use_odd = odd_q;
    end
    if (use_odd) begin
      chk_sample = CHK_ODD;
    end else begin
      chk_sample = CHK_EVEN;
    end
`ifdef J204C_TXGEN_PRBS_EN
    if (start_run) begin
      lfsr_src = 7'h7F;
    end else begin
      lfsr_src = lfsr_q;
    end
    prbs_res = prbs7_beat(lfsr_src);
    lfsr_nxt = prbs_res[DATA_W+6:DATA_W];
`endif
    case (gen_mode)
      2'd0:    gen_data = ramp_beat;
      2'd1:    gen_data = {NS{gen_const}};
      2'd2:    gen_data = {NS{chk_sample}};
`ifdef J204C_TXGEN_PRBS_EN
      2'd3:    gen_data = prbs_res[DATA_W-1:0];
`else
      2'd3:    gen_data = ramp_beat;
`endif
      default: gen_data = ramp_beat;
    endcase
  end

  // Next-state logic: FSM, handshake register, generator state and counters.
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    data_d      = data_q;
    base_d      = base_q;
    odd_d       = odd_q;
`ifdef J204C_TXGEN_PRBS_EN
    lfsr_d      = lfsr_q;
`endif

    // Transfer takes priority over stall; both saturate.
    if (xfer) begin
      beat_cnt_d  = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + CNT_W'(1);
      stall_cnt_d = stall_cnt_q;
    end else if (stall) begin
      beat_cnt_d  = beat_cnt_q;
      stall_cnt_d = (&stall_cnt_q) ? stall_cnt_q : stall_cnt_q + CNT_W'(1);
    end else begin
      beat_cnt_d  = beat_cnt_q;
      stall_cnt_d = stall_cnt_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (gen_enable) begin
          state_d     = ST_ARM;
          beat_cnt_d  = '0;
          stall_cnt_d = '0;
          base_d      = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (!gen_enable) begin
          state_d = ST_IDLE;
        end else if (link_up) begin
          state_d = ST_RUN;
          valid_d = 1'b1;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_RUN: begin
        // valid is always high in RUN, so a non-stalled exit means the
        // current beat transfers on this edge.
        if (exiting) begin
          if (valid_q && !tx_avst_ready) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        // Losing the link abandons the held beat.
        if (!link_up) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else if (tx_avst_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (gen_beat) begin
      data_d = gen_data;
      base_d = base_q + SAMPLE_W'(NS);
      odd_d  = ~use_odd;
`ifdef J204C_TXGEN_PRBS_EN
      lfsr_d = lfsr_nxt;
`endif
    end else begin
      data_d = data_q;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State registers with synchronous reset.
  always_ff @(posedge jesd_link_clk) begin
    if (jesd_link_reset) begin
      state_q     <= ST_IDLE;
      valid_q     <= 1'b0;
      data_q      <= '0;
      beat_cnt_q  <= '0;
      stall_cnt_q <= '0;
      base_q      <= '0;
      odd_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef J204C_TXGEN_PRBS_EN
      lfsr_q      <= 7'h7F;
`endif
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      beat_cnt_q  <= beat_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      base_q      <= base_d;
      odd_q       <= odd_d;
      busy_q      <= busy_d;
`ifdef J204C_TXGEN_PRBS_EN
      lfsr_q      <= lfsr_d;
`endif
    end
  end

  assign tx_avst_data  = data_q;
  assign tx_avst_valid = valid_q;
  assign beat_cnt      = beat_cnt_q;
  assign stall_cnt     = stall_cnt_q;
  assign gen_busy      = busy_q;

endmodule
